// File: rtl/scanline_buf.sv
// scanline_buf: double-banked 256 x 6 line buffer between a PPU writer and a
// VGA reader. The PPU fills one bank while the VGA shows the other, and the
// banks swap when the reader has shown the current line enough times and the
// writer has completed a full line.
//
// Configuration macro: SCANLINE_DOUBLE_EN
//   defined   -> each stored line is shown on two VGA rows (N = 2)
//   undefined -> each stored line is shown on one VGA row (N = 1)
module scanline_buf #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              ppu_pix_en,
  input  logic [DATA_W-1:0] ppu_pix,
  output logic              wr_ready,
  input  logic [7:0]        vga_buf_idx,
  output logic [DATA_W-1:0] vga_buf_out,
  input  logic              vga_row_end,
  output logic              overflow,
  output logic              underrun,
  input  logic              status_clr
);

`ifdef SCANLINE_DOUBLE_EN
  localparam int REP_N = 2;
`else
  localparam int REP_N = 1;
`endif

  localparam logic [0:0]        REP_LAST = 1'(REP_N - 1);
  localparam logic [DATA_W-1:0] BLACK    = DATA_W'(8'h0F);

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_t;

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic              wr_bank;
  logic [7:0]        wr_col;
  logic [0:0]        rd_rep;
  logic              rd_valid;
  logic [DATA_W-1:0] mem [0:511];

  logic wr_fire;
  logic pix_drop;
  logic line_done;
  logic row_tick;
  logic rel_ev;
  logic line_full;
  logic swap_ev;
  logic rpt_ev;

  // Event decode: everything is qualified by clk_en so a frozen cycle is inert
  always_comb begin
    wr_fire   = clk_en & ppu_pix_en & (state == WR_FILL);
    pix_drop  = clk_en & ppu_pix_en & (state == WR_WAIT);
    line_done = wr_fire & (wr_col == 8'hFF);
    row_tick  = clk_en & vga_row_end;
    rel_ev    = row_tick & (rd_rep == REP_LAST);
    // A line completed by this very cycle's write already counts as full
    line_full = (state == WR_WAIT) | line_done;
    swap_ev   = rel_ev & line_full;
    rpt_ev    = rel_ev & ~line_full;
  end

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WR_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Write FSM next state: a swap reopens filling, a completed line waits
  always_comb begin
    state_nxt = state;
    if (swap_ev) begin
      state_nxt = WR_FILL;
    end else if (line_done) begin
      state_nxt = WR_WAIT;
    end
  end

  // Write FSM outputs
  always_comb begin
    wr_ready = (state == WR_FILL);
  end

  // Write column: advances per accepted pixel, wraps at 255, restarts on swap
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col <= 8'd0;
    end else if (swap_ev) begin
      wr_col <= 8'd0;
    end else if (wr_fire) begin
      wr_col <= wr_col + 8'd1;
    end
  end

  // Bank select and read-valid: flip together on each swap
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_valid <= 1'b0;
    end else if (swap_ev) begin
      wr_bank  <= ~wr_bank;
      rd_valid <= 1'b1;
    end
  end

`ifdef SCANLINE_DOUBLE_EN
  // Row repeat counter: counts row ends until the line has been shown N times
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rep <= 1'b0;
    end else if (row_tick) begin
      rd_rep <= rel_ev ? 1'b0 : rd_rep + 1'b1;
    end
  end
`else
  // Single-row mode: every row end is a release
  assign rd_rep = 1'b0;
`endif

  // Sticky status flags: a set event in the same cycle beats status_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else if (clk_en) begin
      overflow <= (overflow & ~status_clr) | pix_drop;
      underrun <= (underrun & ~status_clr) | rpt_ev;
    end
  end

  // Pixel storage write port: bank contents are never reset
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem[{wr_bank, wr_col}] <= ppu_pix;
    end
  end

  // Read port: combinational, black until a full line has been swapped in
  assign vga_buf_out = rd_valid ? mem[{~wr_bank, vga_buf_idx}] : BLACK;

endmodule

// File: tb/tb_scanline_buf.sv
// tb_scanline_buf: randomized and directed bench for scanline_buf against a
// line-level reference model (two arrays, a fill pointer and a repeat count).
module tb_scanline_buf;

`ifdef SCANLINE_DOUBLE_EN
  localparam int REP_N = 2;
`else
  localparam int REP_N = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       ppu_pix_en;
  logic [5:0] ppu_pix;
  logic       wr_ready;
  logic [7:0] vga_buf_idx;
  logic [5:0] vga_buf_out;
  logic       vga_row_end;
  logic       overflow;
  logic       underrun;
  logic       status_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [5:0] m_bank [2][256];
  bit         m_wb;
  int         m_col;
  bit         m_wait;
  int         m_rep;
  bit         m_valid;
  bit         m_ovf;
  bit         m_und;

  scanline_buf dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .ppu_pix_en  (ppu_pix_en),
    .ppu_pix     (ppu_pix),
    .wr_ready    (wr_ready),
    .vga_buf_idx (vga_buf_idx),
    .vga_buf_out (vga_buf_out),
    .vga_row_end (vga_row_end),
    .overflow    (overflow),
    .underrun    (underrun),
    .status_clr  (status_clr)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input bit pe, input logic [5:0] px, input bit re,
                                     input bit clr, input bit en, input bit r);
    bit full_now;
    bit set_o;
    bit set_u;
    if (r) begin
      m_wb = 0; m_col = 0; m_wait = 0; m_rep = 0;
      m_valid = 0; m_ovf = 0; m_und = 0;
      return;
    end
    if (!en) return;
    set_o = 0;
    set_u = 0;
    full_now = m_wait;
    if (pe) begin
      if (m_wait) set_o = 1;
      else begin
        m_bank[m_wb][m_col] = px;
        if (m_col == 255) begin
          m_col = 0;
          m_wait = 1;
          full_now = 1;
        end else m_col = m_col + 1;
      end
    end
    if (re) begin
      m_rep = m_rep + 1;
      if (m_rep == REP_N) begin
        m_rep = 0;
        if (full_now) begin
          m_wb = ~m_wb;
          m_valid = 1;
          m_wait = 0;
          m_col = 0;
        end else set_u = 1;
      end
    end
    if (clr) begin
      m_ovf = 0;
      m_und = 0;
    end
    if (set_o) m_ovf = 1;
    if (set_u) m_und = 1;
  endfunction

  function automatic logic [5:0] m_out(input logic [7:0] idx);
    return m_valid ? m_bank[~m_wb][idx] : 6'h0F;
  endfunction

  // one clock: inputs held across the rising edge, then returned to idle
  task automatic cyc(input bit pe, input logic [5:0] px, input bit re,
                     input bit clr, input bit en, input bit r);
    ppu_pix_en  = pe;
    ppu_pix     = px;
    vga_row_end = re;
    status_clr  = clr;
    clk_en      = en;
    rst         = r;
    @(posedge clk);
    model_step(pe, px, re, clr, en, r);
    #1;
    ppu_pix_en  = 1'b0;
    vga_row_end = 1'b0;
    status_clr  = 1'b0;
    clk_en      = 1'b1;
    rst         = 1'b0;
  endtask

  task automatic do_reset();
    cyc(0, 6'h0, 0, 0, 1, 1);
  endtask

  task automatic release_line();
    repeat (REP_N) cyc(0, 6'h0, 1, 0, 1, 0);
  endtask

  task automatic write_rand(input int n);
    for (int i = 0; i < n; i++) cyc(1, 6'($urandom), 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    write_rand(20);
    // reset while clk_en is low must still take effect
    cyc(1, 6'h2A, 1, 0, 0, 1);
    vga_buf_idx = 8'h10;
    #1;
    n_checks++;
    if (vga_buf_out !== 6'h0F) begin
      n_fail++; $display("FAIL reset_out got=%h exp=0f", vga_buf_out);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow);
    end
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_full_line();
    do_reset();
    for (int c = 0; c < 256; c++) cyc(1, 6'(c), 0, 0, 1, 0);
    release_line();
    vga_buf_idx = 8'h45;
    #1;
    n_checks++;
    if (vga_buf_out !== 6'h05) begin
      n_fail++; $display("FAIL full_line_45 got=%h exp=05", vga_buf_out);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_line_ready got=%b exp=1", wr_ready);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vga_buf_idx = 8'($urandom);
      #1;
      n_checks++;
      if (vga_buf_out !== 6'(vga_buf_idx)) begin
        n_fail++; $display("FAIL full_line_idx%0d got=%h exp=%h", vga_buf_idx, vga_buf_out, 6'(vga_buf_idx));
      end
    end
  endtask

  task automatic test_overflow();
    logic [5:0] line_a [256];
    do_reset();
    for (int c = 0; c < 256; c++) begin
      line_a[c] = 6'($urandom);
      cyc(1, line_a[c], 0, 0, 1, 0);
    end
    write_rand(3);
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL ovf_ready got=%b exp=0", wr_ready);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow);
    end
    release_line();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vga_buf_idx = (k < 3) ? 8'(k) : 8'($urandom);
      #1;
      n_checks++;
      if (vga_buf_out !== line_a[vga_buf_idx]) begin
        n_fail++; $display("FAIL ovf_line_idx%0d got=%h exp=%h", vga_buf_idx, vga_buf_out, line_a[vga_buf_idx]);
      end
    end
    cyc(0, 6'h0, 0, 1, 1, 0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
  endtask

  task automatic test_underrun();
    logic [5:0] line_a [256];
    do_reset();
    for (int c = 0; c < 256; c++) begin
      line_a[c] = 6'($urandom);
      cyc(1, line_a[c], 0, 0, 1, 0);
    end
    release_line();
    write_rand(100);
    release_line();
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++; $display("FAIL und_flag got=%b exp=1", underrun);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vga_buf_idx = 8'($urandom);
      #1;
      n_checks++;
      if (vga_buf_out !== line_a[vga_buf_idx]) begin
        n_fail++; $display("FAIL und_old_idx%0d got=%h exp=%h", vga_buf_idx, vga_buf_out, line_a[vga_buf_idx]);
      end
    end
    // column 100 kept: exactly 156 more pixels complete the line
    write_rand(155);
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL und_col_early got=%b exp=1", wr_ready);
    end
    write_rand(1);
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL und_col_full got=%b exp=0", wr_ready);
    end
    release_line();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vga_buf_idx = 8'($urandom);
      #1;
      n_checks++;
      if (vga_buf_out !== m_out(vga_buf_idx)) begin
        n_fail++; $display("FAIL und_new_idx%0d got=%h exp=%h", vga_buf_idx, vga_buf_out, m_out(vga_buf_idx));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [5:0] first;
    logic [5:0] last;
    logic [5:0] pnew;
    do_reset();
    write_rand(256);
    release_line();
    first = 6'($urandom);
    cyc(1, first, 0, 0, 1, 0);
    write_rand(254);
    if (REP_N == 2) cyc(0, 6'h0, 1, 0, 1, 0);
    last = 6'($urandom);
    cyc(1, last, 1, 0, 1, 0);
    vga_buf_idx = 8'hFF;
    #1;
    n_checks++;
    if (vga_buf_out !== last) begin
      n_fail++; $display("FAIL same_cyc_255 got=%h exp=%h", vga_buf_out, last);
    end
    vga_buf_idx = 8'h00;
    #1;
    n_checks++;
    if (vga_buf_out !== first) begin
      n_fail++; $display("FAIL same_cyc_0 got=%h exp=%h", vga_buf_out, first);
    end
    n_checks++;
    if (underrun !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_cyc_flags got=und%b/rdy%b exp=und0/rdy1", underrun, wr_ready);
    end
    pnew = first ^ 6'h3F;
    cyc(1, pnew, 0, 0, 1, 0);
    write_rand(255);
    release_line();
    vga_buf_idx = 8'h00;
    #1;
    n_checks++;
    if (vga_buf_out !== pnew) begin
      n_fail++; $display("FAIL same_cyc_next_col0 got=%h exp=%h", vga_buf_out, pnew);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] line_c [256];
    do_reset();
    write_rand(256);
    release_line();
    write_rand(50);
    do_reset();
    vga_buf_idx = 8'h20;
    #1;
    n_checks++;
    if (vga_buf_out !== 6'h0F || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state got=%h/rdy%b exp=0f/rdy1", vga_buf_out, wr_ready);
    end
    for (int c = 0; c < 256; c++) begin
      line_c[c] = 6'($urandom);
      cyc(1, line_c[c], 0, 0, 1, 0);
    end
    release_line();
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      vga_buf_idx = 8'(c);
      #1;
      n_checks++;
      if (vga_buf_out !== line_c[c]) begin
        n_fail++; $display("FAIL rst_mid_col%0d got=%h exp=%h", c, vga_buf_out, line_c[c]);
      end
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    write_rand(256);
    release_line();
    write_rand(40);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 6'($urandom), 1, 1, 0, 0);
      vga_buf_idx = 8'($urandom);
      #1;
      n_checks++;
      if (vga_buf_out !== m_out(vga_buf_idx)) begin
        n_fail++; $display("FAIL clk_en_track_idx%0d got=%h exp=%h", vga_buf_idx, vga_buf_out, m_out(vga_buf_idx));
      end
    end
    write_rand(215);
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL clk_en_col got=%b exp=1", wr_ready);
    end
    write_rand(1);
    release_line();
    for (int c = 0; c < 256; c += 5) begin
      @(negedge clk);
      vga_buf_idx = 8'(c);
      #1;
      n_checks++;
      if (vga_buf_out !== m_out(vga_buf_idx)) begin
        n_fail++; $display("FAIL clk_en_line_col%0d got=%h exp=%h", c, vga_buf_out, m_out(vga_buf_idx));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 149) == 0,
          $urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0, 0);
      vga_buf_idx = 8'($urandom);
      #1;
      n_checks++;
      if (wr_ready !== !m_wait || overflow !== m_ovf || underrun !== m_und) begin
        n_fail++;
        $display("FAIL rand_flags cyc=%0d got=rdy%b/ovf%b/und%b exp=rdy%b/ovf%b/und%b",
                 k, wr_ready, overflow, underrun, !m_wait, m_ovf, m_und);
      end
      n_checks++;
      if (vga_buf_out !== m_out(vga_buf_idx)) begin
        n_fail++; $display("FAIL rand_out cyc=%0d idx=%0d got=%h exp=%h", k, vga_buf_idx, vga_buf_out, m_out(vga_buf_idx));
      end
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; ppu_pix_en = 1'b0; ppu_pix = 6'h0;
    vga_buf_idx = 8'h0; vga_row_end = 1'b0; status_clr = 1'b0;
    do_reset();
    test_reset();
    test_full_line();
    test_overflow();
    test_underrun();
    test_same_cycle();
    test_reset_mid();
    test_clk_en();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
